// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared types for the ALU command sequencer: ALU op encoding, sequencer
//   FSM states and response flag bit positions.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EXEC,
      ST_RESP
   } state_e;

   // Bit positions inside rsp_flags = {overflow, carry, zero}
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo
//   Synchronous command FIFO. Head entry is presented combinationally on
//   o_rdata; a pop advances the read pointer. Pointers wrap modulo DEPTH.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   i_push, i_wdata  write request and entry (ignored while full)
//   i_pop            read request (ignored while empty)
//   o_rdata          current head entry
//   o_count          number of stored entries (0..DEPTH)
//   o_full, o_empty  occupancy status
module alu_seq_fifo #(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 11
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic [ENTRY_W-1:0]           i_wdata,
   input  logic                         i_pop,
   output logic [ENTRY_W-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0]       o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_do_push && !w_do_pop)
            r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop)
            r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-side initiator for a combinational ALU. Commands are queued in
//   a FIFO, then issued one at a time: IDLE -> LOAD (registers ALU inputs,
//   pops FIFO) -> EXEC (captures ALU outputs) -> RESP (holds response until
//   accepted). Responses return in command order, one per command.
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   When defined, cmd_chain is stored per entry and a chained entry takes
//   operand A from the last captured rsp_result.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_a, cmd_b, cmd_chain  command payload
//   alu_a, alu_b, alu_sel            registered ALU stimulus
//   alu_result, alu_zero, alu_carry, alu_overflow  ALU outputs
//   rsp_valid/rsp_ready              response handshake
//   rsp_result, rsp_flags, rsp_op    response payload, flags {ovf,carry,zero}
//   busy                             FSM not idle or FIFO non-empty
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_chain,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [2:0]       rsp_flags,
   output logic [2:0]       rsp_op,
   output logic             busy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ALU_SEQ_CHAIN_EN
   localparam int ENTRY_W = 4 + 2 * WIDTH;
`else
   localparam int ENTRY_W = 3 + 2 * WIDTH;
`endif

   state_e             r_state;
   logic [WIDTH-1:0]   r_alu_a;
   logic [WIDTH-1:0]   r_alu_b;
   logic [2:0]         r_alu_sel;
   logic               r_rsp_valid;
   logic [WIDTH-1:0]   r_rsp_result;
   logic [2:0]         r_rsp_flags;
   logic [2:0]         r_rsp_op;

   logic               w_push;
   logic               w_pop;
   logic [ENTRY_W-1:0] w_wdata;
   logic [ENTRY_W-1:0] w_rdata;
   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic [2:0]         w_head_op;
   logic [WIDTH-1:0]   w_head_a;
   logic [WIDTH-1:0]   w_head_b;

`ifdef ALU_SEQ_CHAIN_EN
   logic               w_head_chain;
   assign w_wdata      = {cmd_chain, cmd_op, cmd_a, cmd_b};
   assign w_head_chain = w_rdata[ENTRY_W-1];
`else
   logic               w_unused_chain;
   assign w_wdata        = {cmd_op, cmd_a, cmd_b};
   assign w_unused_chain = cmd_chain;
`endif

   assign w_head_op = w_rdata[2*WIDTH +: 3];
   assign w_head_a  = w_rdata[WIDTH +: WIDTH];
   assign w_head_b  = w_rdata[0 +: WIDTH];

   // cmd_ready depends only on the registered count: no push-when-full
   // bypass, and no path from rsp_ready.
   assign cmd_ready = (w_count < CNT_W'(DEPTH));
   assign w_push    = cmd_valid && !w_full;
   assign w_pop     = (r_state == ST_LOAD);

   alu_seq_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_sel    <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
         r_rsp_op     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) r_state <= ST_LOAD;
            end
            ST_LOAD: begin
`ifdef ALU_SEQ_CHAIN_EN
               r_alu_a <= w_head_chain ? r_rsp_result : w_head_a;
`else
               r_alu_a <= w_head_a;
`endif
               r_alu_b   <= w_head_b;
               r_alu_sel <= w_head_op;
               r_state   <= ST_EXEC;
            end
            ST_EXEC: begin
               r_rsp_result            <= alu_result;
               r_rsp_flags[FLAG_ZERO]  <= alu_zero;
               r_rsp_flags[FLAG_CARRY] <= alu_carry;
               r_rsp_flags[FLAG_OVF]   <= alu_overflow;
               r_rsp_op                <= r_alu_sel;
               r_rsp_valid             <= 1'b1;
               r_state                 <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= w_empty ? ST_IDLE : ST_LOAD;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_sel    = r_alu_sel;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;
   assign rsp_op     = r_rsp_op;
   assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Bench for alu_cmd_sequencer (WIDTH 4, DEPTH 4). Provides a behavioural
//   4-bit ALU on the ALU side and keeps an in-order queue of expected
//   responses, one per accepted command.
module tb_alu_cmd_sequencer;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       cmd_chain;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_result;
   logic       alu_zero;
   logic       alu_carry;
   logic       alu_overflow;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_result;
   logic [2:0] rsp_flags;
   logic [2:0] rsp_op;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_rsp    = 0;

   typedef struct {
      logic [3:0] res;
      logic [2:0] flags;
      logic [2:0] op;
   } rsp_t;

   rsp_t       exp_q[$];
   logic [3:0] model_last = 4'd0;

   alu_cmd_sequencer #(
      .WIDTH (4),
      .DEPTH (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_chain    (cmd_chain),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_sel      (alu_sel),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_carry    (alu_carry),
      .alu_overflow (alu_overflow),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_flags    (rsp_flags),
      .rsp_op       (rsp_op),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 4-bit ALU: returns {overflow, carry, zero, result[3:0]}.
   // SUB carry is the borrow (a < b).
   function automatic logic [6:0] alu_f(input logic [2:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
      logic [4:0] s;
      logic [3:0] r;
      logic       c;
      logic       v;
      s = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[3:0];
            c = s[4];
            v = (a[3] == b[3]) && (r[3] != a[3]);
         end
         3'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[3] != b[3]) && (r[3] != a[3]);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
         default: begin r = {1'b0, a[3:1]}; c = a[0]; end
      endcase
      return {v, c, (r == 4'd0), r};
   endfunction

   always_comb begin
      {alu_overflow, alu_carry, alu_zero, alu_result} = alu_f(alu_sel, alu_a, alu_b);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshakes are sampled on the falling edge: the values seen here are
   // the ones the next rising edge acts on.
   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid && cmd_ready) begin
            logic [3:0] a_eff;
            logic [6:0] r;
            rsp_t       e;
            a_eff = cmd_a;
`ifdef ALU_SEQ_CHAIN_EN
            if (cmd_chain) a_eff = model_last;
`endif
            r = alu_f(cmd_op, a_eff, cmd_b);
            model_last = r[3:0];
            e.res   = r[3:0];
            e.flags = r[6:4];
            e.op    = cmd_op;
            exp_q.push_back(e);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("rsp_spurious", rsp_valid, 1'b0);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               check_eq("rsp_result", rsp_result, e.res);
               check_eq("rsp_flags", rsp_flags, e.flags);
               check_eq("rsp_op", rsp_op, e.op);
               n_rsp++;
            end
         end
      end
   end

   task automatic check_reset_values(input string pfx);
      check_eq({pfx, "_cmd_ready"}, cmd_ready, 1'b1);
      check_eq({pfx, "_alu_a"}, alu_a, 4'd0);
      check_eq({pfx, "_alu_b"}, alu_b, 4'd0);
      check_eq({pfx, "_alu_sel"}, alu_sel, 3'd0);
      check_eq({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
      check_eq({pfx, "_rsp_result"}, rsp_result, 4'd0);
      check_eq({pfx, "_rsp_flags"}, rsp_flags, 3'd0);
      check_eq({pfx, "_rsp_op"}, rsp_op, 3'd0);
      check_eq({pfx, "_busy"}, busy, 1'b0);
   endtask

   // One command into an idle sequencer, checked cycle by cycle.
   task automatic single(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic ch, input logic [3:0] exp_a,
                         input logic [3:0] exp_res, input logic [2:0] exp_fl);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch;
      rsp_ready = 1'b1;
      tick();                                   // edge N: accepted
      cmd_valid = 1'b0;
      check_eq("lat_n0_valid", rsp_valid, 1'b0);
      check_eq("lat_n0_busy", busy, 1'b1);
      tick();                                   // N+1: LOAD
      check_eq("lat_n1_valid", rsp_valid, 1'b0);
      tick();                                   // N+2: EXEC
      check_eq("lat_n2_alu_a", alu_a, exp_a);
      check_eq("lat_n2_alu_b", alu_b, b);
      check_eq("lat_n2_alu_sel", alu_sel, op);
      check_eq("lat_n2_valid", rsp_valid, 1'b0);
      tick();                                   // N+3: RESP
      check_eq("lat_n3_valid", rsp_valid, 1'b1);
      check_eq("lat_n3_result", rsp_result, exp_res);
      check_eq("lat_n3_flags", rsp_flags, exp_fl);
      check_eq("lat_n3_op", rsp_op, op);
      tick();                                   // handshake done
      check_eq("lat_n4_valid", rsp_valid, 1'b0);
      check_eq("lat_n4_busy", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_chain = 1'b0;
      rsp_ready = 1'b0;
      tick(); tick();
      check_reset_values("rst");
      reset = 1'b0;
      tick();

      // Directed single commands
      single(3'd0, 4'd3, 4'd4, 1'b0, 4'd3, 4'd7, 3'b000);
      single(3'd0, 4'd7, 4'd1, 1'b0, 4'd7, 4'd8, 3'b100);
      single(3'd1, 4'd5, 4'd5, 1'b0, 4'd5, 4'd0, 3'b001);
`ifdef ALU_SEQ_CHAIN_EN
      single(3'd0, 4'd2, 4'd3, 1'b0, 4'd2, 4'd5, 3'b000);
      single(3'd0, 4'd9, 4'd1, 1'b1, 4'd5, 4'd6, 3'b000);
`endif

      // Fill with rsp_ready low, then hold backpressure
      begin
         int         acc;
         int         base;
         logic [6:0] r0;
         logic [3:0] a0, b0;
         logic [2:0] op0;
         acc = 0;
         rsp_ready = 1'b0;
         cmd_valid = 1'b1; cmd_chain = 1'b0;
         cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
         op0 = cmd_op; a0 = cmd_a; b0 = cmd_b;
         r0 = alu_f(op0, a0, b0);
         for (int i = 0; i < 12; i++) begin
            logic take;
            take = cmd_ready;
            tick();
            if (take) begin
               acc++;
               cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
            end
         end
         cmd_valid = 1'b0;
         check_eq("fill_accepted", acc, 5);
         check_eq("fill_cmd_ready", cmd_ready, 1'b0);
         for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp_valid", rsp_valid, 1'b1);
            check_eq("bp_result", rsp_result, r0[3:0]);
            check_eq("bp_flags", rsp_flags, r0[6:4]);
            check_eq("bp_op", rsp_op, op0);
            check_eq("bp_alu_a", alu_a, a0);
            check_eq("bp_alu_b", alu_b, b0);
            check_eq("bp_alu_sel", alu_sel, op0);
         end
         base = n_rsp;
         rsp_ready = 1'b1;
         for (int i = 0; i < 40 && !((n_rsp - base) == 5 && !busy); i++) tick();
         check_eq("fill_rsp_count", n_rsp - base, 5);
         check_eq("fill_busy", busy, 1'b0);
      end

      // Reset while a command is in EXEC with another queued
      begin
         int base;
         rsp_ready = 1'b1;
         cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd1; cmd_b = 4'd2; cmd_chain = 1'b0;
         tick();                                // edge N: first accepted
         cmd_op = 3'd2; cmd_a = 4'hF; cmd_b = 4'h3;
         tick();                                // second accepted, LOAD
         cmd_valid = 1'b0;
         tick();                                // EXEC
         check_eq("pre_rst_busy", busy, 1'b1);
         reset = 1'b1;
         #1;
         check_reset_values("midrst");
         exp_q.delete();
         model_last = 4'd0;
         tick(); tick();
         reset = 1'b0;
         base = n_rsp;
         for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("post_rst_valid", rsp_valid, 1'b0);
         end
         check_eq("post_rst_busy", busy, 1'b0);
         check_eq("post_rst_rsp_count", n_rsp - base, 0);
      end

      // Randomized traffic against the response queue
      for (int i = 0; i < 400; i++) begin
         cmd_valid = ($urandom_range(0, 99) < 60);
         cmd_op    = 3'($urandom);
         cmd_a     = 4'($urandom);
         cmd_b     = 4'($urandom);
         cmd_chain = 1'($urandom_range(0, 1));
         rsp_ready = ($urandom_range(0, 99) < 70);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 200 && !(exp_q.size() == 0 && !busy); i++) tick();
      check_eq("drain_queue_empty", exp_q.size(), 0);
      check_eq("drain_busy", busy, 1'b0);
      check_eq("drain_cmd_ready", cmd_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the combinational `alu_4bit` datapath. Accepts operation requests over a valid/ready channel and buffers them in a small FIFO. Drives the ALU operand and select lines from registers, captures result and flags, and returns them over a valid/ready response channel. Sits between a bus/test driver and the ALU, so the ALU sees only stable, registered stimulus.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width; must match the attached ALU.
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: rising-edge clock.
  - `reset` in 1: asynchronous, active-high reset.
- Command channel:
  - `cmd_valid` in 1: command offered.
  - `cmd_ready` out 1: FIFO can accept.
  - `cmd_op` in 3: operation select.
  - `cmd_a` in WIDTH: operand A.
  - `cmd_b` in WIDTH: operand B.
  - `cmd_chain` in 1: use previous result as A (see Configuration).
- ALU side:
  - `alu_a` out WIDTH, `alu_b` out WIDTH, `alu_sel` out 3: registered ALU stimulus.
  - `alu_result` in WIDTH, `alu_zero` in 1, `alu_carry` in 1, `alu_overflow` in 1: ALU outputs.
- Response channel:
  - `rsp_valid` out 1: response held.
  - `rsp_ready` in 1: consumer accepts.
  - `rsp_result` out WIDTH: captured result.
  - `rsp_flags` out 3: {overflow, carry, zero}.
  - `rsp_op` out 3: op of this response.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- Op encoding (pass-through to ALU): ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101, SHL 110, SHR 111.
- Command handshake: push on `cmd_valid && cmd_ready`. `cmd_ready = (count < DEPTH)`; there is no push-when-full bypass even if a pop occurs the same cycle.
- FSM states and transitions:
  - IDLE: go to LOAD when FIFO is non-empty.
  - LOAD: FIFO head is written into the `alu_a`/`alu_b`/`alu_sel` registers, FIFO pops, then go to EXEC.
  - EXEC: ALU inputs are stable. At the closing edge, capture `alu_result`, the flags and `rsp_op` into response registers, then go to RESP.
  - RESP: `rsp_valid` = 1. On `rsp_ready`, go to LOAD if the FIFO count seen this cycle is non-zero, else IDLE.
- Response registers and `alu_*` outputs hold their values outside LOAD/EXEC. ALU lines change only on the LOAD edge.
- Responses return strictly in command order, exactly one per accepted command.
- Simultaneous FIFO push and pop: count unchanged; pointers wrap modulo DEPTH.
- Reset values (asserted asynchronously, all outputs): `cmd_ready` 1, `alu_a`/`alu_b`/`alu_sel` 0, `rsp_valid` 0, `rsp_result` 0, `rsp_flags` 0, `rsp_op` 0, `busy` 0; FSM IDLE, FIFO empty.
- Reset mid-operation: FIFO contents and the in-flight command are discarded; no response is produced for them.

## Timing
- Latency, idle and empty: command accepted at edge N → LOAD after edge N+1 → EXEC after edge N+2 → `rsp_valid` high after edge N+3.
- Back-to-back throughput: one response every 3 cycles while `rsp_ready` = 1.
- RESP holds all `rsp_*` stable until the handshake; `rsp_valid` never drops without `rsp_ready`.
- `cmd_ready` is a registered-count function; no combinational path from `rsp_ready` to `cmd_ready`.

## Configuration
- `ALU_SEQ_CHAIN_EN` defined:
  - `cmd_chain` is stored per FIFO entry.
  - In LOAD, an entry with chain = 1 loads `alu_a` from the last captured `rsp_result` (0 after reset) instead of `cmd_a`.
- Not defined:
  - `cmd_chain` is ignored and not stored; FIFO entry width is 3 + 2·WIDTH.

## Structure
- Package `alu_seq_pkg`: op enum, FSM state enum, flag bit indices (ZERO 0, CARRY 1, OVF 2).
- Sub-module `alu_seq_fifo`: synchronous FIFO parameterised by DEPTH and entry width, exposing `count`/`full`/`empty`.
- FSM, operand registers and response registers live in the top module.

## Test plan
- ADD a=3, b=4, idle, `rsp_ready`=1 → `rsp_result` 7, `rsp_flags` 000, `rsp_valid` after edge N+3.
- ADD 7+1 → result 8, overflow 1; SUB 5−5 → result 0, zero 1 (flags match the ALU model).
- `rsp_ready`=0, push every cycle → exactly 5 commands accepted (1 in RESP + 4 queued), then `cmd_ready` 0; release → 5 in-order responses.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_*` stable, `alu_*` unchanged.
- Assert `reset` during EXEC → all outputs at reset values immediately; no response afterwards.
- With `ALU_SEQ_CHAIN_EN`: ADD 2+3, then ADD chain=1, b=1 → responses 5 then 6.
